// File: rtl/instruction_prefetch_register.sv
// Instruction register with a small prefetch FIFO in front of it.
// The fetch side pushes words with valid/ready. LoadIR moves the oldest word
// into the IR, or takes the offered word directly when the queue is empty.
// Flush empties the queue and marks the IR as stale.
module instruction_prefetch_register #(
    parameter int INS_WIDTH    = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int DEPTH        = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [INS_WIDTH-1:0]              ins_in,
    input  logic                              ins_valid,
    output logic                              ins_ready,
    input  logic                              LoadIR,
    output logic [OPCODE_WIDTH-1:0]           opcode,
    output logic [INS_WIDTH-OPCODE_WIDTH-1:0] data_out,
    output logic                              ir_valid,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INS_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [INS_WIDTH-1:0] ir_q, ir_d;
    logic                 ir_valid_q, ir_valid_d;
    logic                 underflow_q, underflow_d;

    logic push;
    logic pop;
    logic enq;
    logic q_empty;

    // Ready depends only on registered occupancy and flush, never on LoadIR.
    assign ins_ready = !flush && (count_q != FULL_CNT);
    assign push      = ins_valid && ins_ready;
    assign q_empty   = (count_q == '0);

    // Pop the head only when the queue actually holds a word.
    assign pop = !flush && LoadIR && !q_empty;
    // An accepted word goes into the queue unless it is bypassed into the IR.
    assign enq = push && !(LoadIR && q_empty);

    // Next-state for pointers, occupancy and the IR.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        underflow_d = 1'b0;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ir_valid_d = 1'b0;
        end else begin
            if (LoadIR) begin
                if (!q_empty) begin
                    ir_d       = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    ir_valid_d = 1'b1;
                end else if (push) begin
                    ir_d       = ins_in;
                    ir_valid_d = 1'b1;
                end else begin
                    ir_valid_d  = 1'b0;
                    underflow_d = 1'b1;
                end
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            underflow_q <= underflow_d;
        end
    end

    // Queue storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clock) begin
        if (!reset && enq) begin
            mem_q[wr_ptr_q] <= ins_in;
        end
    end

    assign opcode    = ir_q[OPCODE_WIDTH-1:0];
    assign data_out  = ir_q[INS_WIDTH-1:OPCODE_WIDTH];
    assign ir_valid  = ir_valid_q;
    assign count     = count_q;
    assign underflow = underflow_q;

endmodule
